// File: rtl/alu_issue_stage.sv
// ID/EX issue stage ahead of the 32-bit ALU: decodes RV32I into an ALU op, builds
// forwarded operands and holds them in a single valid/ready pipeline register.
module alu_issue_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_aluop,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_funct3,
  output logic            out_is_branch,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR  = 4'd4,
    OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8, OP_SLTU = 4'd9
  } aluop_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [3:0]      aluop;
    logic [4:0]      rd;
    logic            rd_we;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            is_load;
    logic            is_store;
    logic            illegal;
  } entry_t;

  logic            xfer;
  logic            valid_d, valid_q;
  entry_t          entry_d, entry_q;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, imm_u;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0] r, input logic [XLEN-1:0] rf,
    input logic mwe, input logic [4:0] mrd, input logic [XLEN-1:0] md,
    input logic wwe, input logic [4:0] wrd, input logic [XLEN-1:0] wd);
    if (r == 5'd0)             return '0;
    if (mwe && (mrd == r))     return md;
    if (wwe && (wrd == r))     return wd;
    return rf;
  endfunction

  function automatic aluop_e f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'b0};

  assign rs1_val = fwd_sel(rs1, in_rs1_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  assign rs2_val = fwd_sel(rs2, in_rs2_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (xfer)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_comb begin
    entry_d = entry_q;
    if (xfer) begin
      entry_d        = '0;
      entry_d.a      = rs1_val;
      entry_d.b      = rs2_val;
      entry_d.rs2    = rs2_val;
      entry_d.pc     = in_pc;
      entry_d.rd     = rd;
      entry_d.funct3 = funct3;
      entry_d.aluop  = OP_ADD;
      case (opcode)
        OPC_OP: begin
          entry_d.aluop = f3_op(funct3, in_instr[30]);
          entry_d.rd_we = 1'b1;
        end
        OPC_OPIMM: begin
          // funct3 x01 are the shifts: shamt in place of the immediate, and only
          // SRLI/SRAI look at bit 30 (ADDI never becomes SUB)
          entry_d.b     = (funct3[1:0] == 2'b01) ? {27'b0, rs2} : imm_i;
          entry_d.aluop = f3_op(funct3, (funct3 == 3'b101) && in_instr[30]);
          entry_d.rd_we = 1'b1;
        end
        OPC_LOAD: begin
          entry_d.b       = imm_i;
          entry_d.is_load = 1'b1;
          entry_d.rd_we   = 1'b1;
        end
        OPC_STORE: begin
          entry_d.b        = imm_s;
          entry_d.is_store = 1'b1;
        end
        OPC_BRANCH: begin
          entry_d.is_branch = 1'b1;
          case (funct3)
            3'b000, 3'b001: entry_d.aluop = OP_SUB;
            3'b100, 3'b101: entry_d.aluop = OP_SLT;
            3'b110, 3'b111: entry_d.aluop = OP_SLTU;
            default:        entry_d.illegal = 1'b1;
          endcase
        end
        OPC_LUI: begin
          entry_d.a     = '0;
          entry_d.b     = imm_u;
          entry_d.rd_we = 1'b1;
        end
        OPC_AUIPC: begin
          entry_d.a     = in_pc;
          entry_d.b     = imm_u;
          entry_d.rd_we = 1'b1;
        end
        default: entry_d.illegal = 1'b1;
      endcase
      entry_d.rd_we = entry_d.rd_we && (rd != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      entry_q     <= '0;
      entry_q.pc  <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_a         = entry_q.a;
  assign out_b         = entry_q.b;
  assign out_aluop     = entry_q.aluop;
  assign out_rs2_data  = entry_q.rs2;
  assign out_rd        = entry_q.rd;
  assign out_rd_we     = entry_q.rd_we;
  assign out_pc        = entry_q.pc;
  assign out_funct3    = entry_q.funct3;
  assign out_is_branch = entry_q.is_branch;
  assign out_is_load   = entry_q.is_load;
  assign out_is_store  = entry_q.is_store;
  assign out_illegal   = entry_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX stage directly upstream of the 32-bit ALU. It decodes an RV32I instruction into the ALU's 4-bit operation code, builds operands A and B (register, immediate, PC, forwarded result), and holds them in a valid/ready pipeline register. The registered outputs drive the ALU's A, B and ALUOp inputs directly. Destination and branch metadata travel alongside for the EX/MEM stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC, 32'h0000_0000, reset value of out_pc.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  kill the held entry and any instruction accepted this cycle
in_valid  in  1  upstream holds an instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  raw instruction
in_pc  in  32  instruction address
in_rs1_data  in  32  register-file read, rs1
in_rs2_data  in  32  register-file read, rs2
fwd_mem_we  in  1  EX/MEM stage writes a register
fwd_mem_rd  in  5  EX/MEM destination
fwd_mem_data  in  32  EX/MEM result
fwd_wb_we  in  1  MEM/WB stage writes a register
fwd_wb_rd  in  5  MEM/WB destination
fwd_wb_data  in  32  MEM/WB result
out_valid  out  1  registered entry valid
out_ready  in  1  downstream consumes the entry
out_a  out  32  ALU operand A
out_b  out  32  ALU operand B
out_aluop  out  4  ALU operation code
out_rs2_data  out  32  forwarded rs2 value, used as store data
out_rd  out  5  destination register
out_rd_we  out  1  writes rd; forced 0 when rd = 0
out_pc  out  32  PC of the held instruction
out_funct3  out  3  funct3, for the branch/load/store qualifier
out_is_branch  out  1  conditional branch
out_is_load  out  1  load
out_is_store  out  1  store
out_illegal  out  1  unsupported opcode

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_pc=RESET_PC, every other output register=0 (out_aluop=4'b0000).
- Handshake: in_ready = !out_valid || out_ready (combinational). Transfer occurs when in_valid && in_ready. The register loads on transfer. If out_valid && out_ready without a transfer, out_valid goes to 0. While out_valid && !out_ready, all outputs hold stable.
- Latency: 1 cycle from accepted instruction to out_valid. Full throughput of one instruction per cycle when out_ready stays 1.
- flush has priority over a transfer: next cycle out_valid=0, and the data registers may update but are don't-care.
- Operation codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- OP (0110011):
  - A=rs1, B=rs2.
  - funct3 000 gives ADD, or SUB when funct7[5]=1. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA (funct7[5]), 110 OR, 111 AND.
  - rd_we=1.
- OP-IMM (0010011):
  - B = sign-extended I-immediate. For shifts, B = {27'b0, instr[24:20]}.
  - Same funct3 map, except 000 is always ADD. SRAI is selected by instr[30].
- LOAD (0000011): ADD, B=I-imm, is_load=1, rd_we=1.
- STORE (0100011): ADD, B=S-imm, is_store=1, rd_we=0.
- BRANCH (1100011): A=rs1, B=rs2, is_branch=1, rd_we=0.
  - funct3 000/001 gives SUB.
  - 100/101 gives SLT.
  - 110/111 gives SLTU.
  - Other funct3 values set out_illegal=1.
- LUI (0110111): A=0, B={instr[31:12],12'b0}, ADD, rd_we=1.
- AUIPC (0010111): A=in_pc, B=U-imm, ADD, rd_we=1.
- Any other opcode: out_illegal=1, ADD, rd_we=0, is_branch/is_load/is_store=0.
- Forwarding applies to the rs1/rs2 register values before operand selection.
  - If fwd_mem_we && fwd_mem_rd!=0 && fwd_mem_rd==rs, use fwd_mem_data.
  - Otherwise apply the same test to the wb port.
  - Otherwise use the register-file value.
  - The mem port wins when both match.
- Register x0 reads as 0 regardless of the forward ports and register-file data.
- Forwarding is sampled only in the transfer cycle. A stalled entry is not re-forwarded; the hazard unit guarantees correctness.
- All immediate arithmetic is 32-bit with sign extension from instr[31]. No carry or overflow outputs.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, no forwarding → next cycle out_valid=1, A=5, B=7, aluop=0, rd=3, rd_we=1.
- SRAI x4,x1,3 (instr[30]=1), rs1=32'h8000_0000 → aluop=7, B=32'h0000_0003. ADDI imm=-1 → B=32'hFFFF_FFFF, aluop=0.
- SUB x5,x1,x1 with fwd_mem rd=1 data=9 and fwd_wb rd=1 data=4 → A=B=9. Repeat with fwd_mem_rd=0 → A=B=4. Repeat with rs1=x0 and both ports matching rd 0 → A=B=0, rd_we for rd=0 is 0.
- Backpressure: fill the entry, hold out_ready=0 for 3 cycles while in_valid=1 → in_ready=0 and outputs stable. Raise out_ready → the next instruction appears the following cycle with no loss or duplication.
- BLTU rs1=1, rs2=2 → aluop=9, is_branch=1, rd_we=0. Opcode 7'b1111111 → illegal=1, rd_we=0.
- flush asserted together with a transfer → out_valid=0 next cycle. rst asserted mid-stream, asynchronously → out_valid=0 and out_pc=RESET_PC immediately, without waiting for a clock edge.
